crb_transfer_engine: RTL

- Command/Response Buffer (CRB) block. It sits directly downstream of the FIFO buffer in the I/O system.
- It owns the CRB RAM. On c_cmdSend it takes full control of the FIFO buffer address and copies the command into the CRB RAM.
- It then hands the command to the execution engine. On e_execDone it copies the response back into the FIFO buffer.
- During the response copy it drives the FIFO buffer's write strobe and address.

---
 rtl/crb_transfer_engine_if.sv | 40 ++++
 rtl/crb_transfer_engine.sv | 126 ++++++++++++
 2 files changed

// File: rtl/crb_transfer_engine_if.sv
// FIFO-side and execution-engine-side signals of the CRB transfer engine.
// The slave modport is the engine's view; master is the view of its surroundings.
interface crb_transfer_engine_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              f_abort;
  logic              c_cmdSend;
  logic [31:0]       c_cmdSize;
  logic [7:0]        cmdByteIn;
  logic [ADDR_W-1:0] c_cmdInAddr;
  logic              c_cmdDone;
  logic              e_execStart;
  logic [ADDR_W-1:0] e_addr;
  logic [7:0]        e_wrByte;
  logic              e_wren;
  logic [7:0]        e_rdByte;
  logic              e_execDone;
  logic [31:0]       e_rspSize;
  logic [31:0]       c_rspSize;
  logic [ADDR_W-1:0] c_rspInAddr;
  logic              c_rspSend;
  logic [7:0]        rspByteOut;
  logic              c_rspDone;
  logic              crb_busy;
  logic              size_err;

  modport slave (
    input  f_abort, c_cmdSend, c_cmdSize, cmdByteIn, e_addr, e_wrByte, e_wren, e_execDone,
           e_rspSize,
    output c_cmdInAddr, c_cmdDone, e_execStart, e_rdByte, c_rspSize, c_rspInAddr, c_rspSend,
           rspByteOut, c_rspDone, crb_busy, size_err
  );

  modport master (
    output f_abort, c_cmdSend, c_cmdSize, cmdByteIn, e_addr, e_wrByte, e_wren, e_execDone,
           e_rspSize,
    input  c_cmdInAddr, c_cmdDone, e_execStart, e_rdByte, c_rspSize, c_rspInAddr, c_rspSend,
           rspByteOut, c_rspDone, crb_busy, size_err
  );
endinterface

// File: rtl/crb_transfer_engine.sv
// CRB transfer engine: copies a command from the FIFO buffer into the CRB RAM, lends the RAM
// to the execution engine, then streams the response back into the FIFO buffer.
module crb_transfer_engine #(
  parameter int unsigned BUF_SIZE = 4096,
  parameter int unsigned ADDR_W   = 12
) (
  input logic              clock,
  input logic              reset,
  crb_transfer_engine_if.slave bus
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CMD_RD    = 3'd1;
  localparam logic [2:0] CMD_LAST  = 3'd2;
  localparam logic [2:0] EXEC      = 3'd3;
  localparam logic [2:0] RSP_ALIGN = 3'd4;
  localparam logic [2:0] RSP_RD    = 3'd5;
  localparam logic [2:0] RSP_LAST  = 3'd6;

  localparam logic [31:0] BufSize32 = 32'(BUF_SIZE);

  function automatic logic [31:0] clampSize(input logic [31:0] size);
    return (size > BufSize32) ? BufSize32 : size;
  endfunction

  function automatic logic sizeBad(input logic [31:0] size);
    return (size == 32'd0) || (size > BufSize32);
  endfunction

  logic [7:0]        ram [0:BUF_SIZE-1];
  logic [2:0]        state, nextState;
  logic [ADDR_W-1:0] lastIdx;
  logic [ADDR_W-1:0] cmdAddr, cmdWrIdx, rspRdAddr, rspWrAddr;
  logic              cmdWrValid, alignCnt, execFirst, rspSendN, sizeErr;
  logic [31:0]       rspSize;
  logic [7:0]        rdByte, rspByte;
  logic              cmdStart, rspStart;

  assign cmdStart = (state == IDLE) && bus.c_cmdSend && !bus.f_abort;
  assign rspStart = (state == EXEC) && bus.e_execDone && !bus.f_abort;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (bus.c_cmdSend) nextState = (bus.c_cmdSize == 32'd0) ? CMD_LAST : CMD_RD;
      CMD_RD:    if (cmdAddr == lastIdx) nextState = CMD_LAST;
      CMD_LAST:  nextState = EXEC;
      EXEC:      if (bus.e_execDone) nextState = RSP_ALIGN;
      RSP_ALIGN: if (alignCnt) nextState = (rspSize == 32'd0) ? RSP_LAST : RSP_RD;
      RSP_RD:    if (rspRdAddr == lastIdx) nextState = RSP_LAST;
      RSP_LAST:  nextState = IDLE;
      default:   nextState = IDLE;
    endcase
    if (bus.f_abort) nextState = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lastIdx    <= '0;
      cmdAddr    <= '0;
      cmdWrIdx   <= '0;
      cmdWrValid <= 1'b0;
      rspRdAddr  <= '0;
      rspWrAddr  <= '0;
      alignCnt   <= 1'b0;
      execFirst  <= 1'b0;
      rspSendN   <= 1'b1;
      sizeErr    <= 1'b0;
      rspSize    <= '0;
      rspByte    <= '0;
    end else begin
      state <= nextState;
      // Read data from the FIFO arrives one cycle after its address, so the write trails by one.
      cmdWrValid <= (state == CMD_RD) && !bus.f_abort;
      cmdWrIdx   <= cmdAddr;
      execFirst  <= (state == CMD_LAST) && !bus.f_abort;
      rspSendN   <= !((state == RSP_RD) && !bus.f_abort);

      if (cmdStart) begin
        cmdAddr <= '0;
        lastIdx <= ADDR_W'(clampSize(bus.c_cmdSize) - 32'd1);
        sizeErr <= sizeBad(bus.c_cmdSize);
      end else if ((state == CMD_RD) && (cmdAddr != lastIdx)) begin
        cmdAddr <= cmdAddr + ADDR_W'(1);
      end

      if (rspStart) begin
        lastIdx   <= ADDR_W'(clampSize(bus.e_rspSize) - 32'd1);
        rspSize   <= clampSize(bus.e_rspSize);
        sizeErr   <= sizeErr | sizeBad(bus.e_rspSize);
        alignCnt  <= 1'b0;
        rspRdAddr <= '0;
      end else if (state == RSP_ALIGN) begin
        alignCnt <= 1'b1;
      end

      if (state == RSP_RD) begin
        rspByte   <= ram[rspRdAddr];
        rspWrAddr <= rspRdAddr;
        if (rspRdAddr != lastIdx) rspRdAddr <= rspRdAddr + ADDR_W'(1);
      end
    end
  end

  // RAM contents and the exec read register are deliberately not reset.
  always_ff @(posedge clock) begin
    if (cmdWrValid) begin
      ram[cmdWrIdx] <= bus.cmdByteIn;
    end else if ((state == EXEC) && bus.e_wren) begin
      ram[bus.e_addr] <= bus.e_wrByte;
    end
    if (state == EXEC) rdByte <= ram[bus.e_addr];
  end

  assign bus.c_cmdInAddr = cmdAddr;
  assign bus.c_cmdDone   = (state == CMD_LAST);
  assign bus.e_execStart = execFirst;
  assign bus.e_rdByte    = rdByte;
  assign bus.c_rspSize   = rspSize;
  assign bus.c_rspInAddr = rspWrAddr;
  assign bus.c_rspSend   = rspSendN;
  assign bus.rspByteOut  = rspByte;
  assign bus.c_rspDone   = (state == RSP_LAST);
  assign bus.crb_busy    = (state != IDLE);
  assign bus.size_err    = sizeErr;
endmodule
